// File: rtl/major_state_sequencer.sv
// Major-state sequencer: Fetch/Auto1/Auto2/Ind plus NPHASES execute phases, each a 2-clock ck level with a stb.
// Optional single-step start input STEP is enabled by defining SEQ_SINGLE_STEP_EN.
module major_state_sequencer #(
    parameter int NPHASES = 6,
    parameter int PW      = 4
) (
`ifdef SEQ_SINGLE_STEP_EN
    input  logic               STEP,
`endif
    input  logic               CLK,
    input  logic               RESET,
    input  logic               RUN,
    input  logic               HALT,
    input  logic               DONE,
    input  logic [1:0]         SEQTYPE,
    output logic               ckFetch,
    output logic               ckAuto1,
    output logic               ckAuto2,
    output logic               ckInd,
    output logic               stbFetch,
    output logic               stbAuto1,
    output logic               stbAuto2,
    output logic               stbInd,
    output logic [NPHASES-1:0] ck,
    output logic [NPHASES-1:0] stb,
    output logic               running,
    output logic               overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_AUTO1,
        S_AUTO2,
        S_IND,
        S_EXEC
    } state_t;

    localparam logic [PW-1:0] LAST = PW'(NPHASES);

    state_t        state, state_n;
    logic [PW-1:0] phase, phase_n;
    logic          cyc_b, cyc_b_n;
    logic          overrun_n;
    logic          single, single_n;
    logic          run_s1, run_s2, run_s3;
    logic          start_run, start_step, go, inst_end, phase_ok;

    assign start_run = run_s2 & ~run_s3;
    assign go        = (start_run | start_step) & ~HALT;
    assign phase_ok  = (phase != '0) && (phase <= LAST);

`ifdef SEQ_SINGLE_STEP_EN
    logic step_s1, step_s2, step_s3;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            step_s1 <= 1'b0;
            step_s2 <= 1'b0;
            step_s3 <= 1'b0;
        end else begin
            step_s1 <= STEP;
            step_s2 <= step_s1;
            step_s3 <= step_s2;
        end
    end

    assign start_step = step_s2 & ~step_s3;
`else
    assign start_step = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            run_s1  <= 1'b0;
            run_s2  <= 1'b0;
            run_s3  <= 1'b0;
            state   <= S_IDLE;
            phase   <= '0;
            cyc_b   <= 1'b0;
            overrun <= 1'b0;
            single  <= 1'b0;
        end else begin
            run_s1  <= RUN;
            run_s2  <= run_s1;
            run_s3  <= run_s2;
            state   <= state_n;
            phase   <= phase_n;
            cyc_b   <= cyc_b_n;
            overrun <= overrun_n;
            single  <= single_n;
        end
    end

    always_comb begin
        state_n   = state;
        phase_n   = phase;
        cyc_b_n   = cyc_b;
        overrun_n = overrun;
        single_n  = single;
        inst_end  = 1'b0;
        case (state)
            S_IDLE: begin
                cyc_b_n = 1'b0;
                phase_n = '0;
                if (go) begin
                    state_n   = S_FETCH;
                    overrun_n = 1'b0;
                    single_n  = start_step & ~start_run;
                end
            end
            S_EXEC: begin
                // A corrupted phase counter abandons the instruction rather than wrapping
                if (!phase_ok) begin
                    state_n = S_IDLE;
                    cyc_b_n = 1'b0;
                    phase_n = '0;
                end else if (!cyc_b) begin
                    cyc_b_n = 1'b1;
                end else begin
                    cyc_b_n = 1'b0;
                    if (DONE) begin
                        inst_end = 1'b1;
                    end else if (phase < LAST) begin
                        phase_n = phase + PW'(1);
                    end else begin
                        inst_end  = 1'b1;
                        overrun_n = 1'b1;
                    end
                end
            end
            default: begin
                if (!cyc_b) begin
                    cyc_b_n = 1'b1;
                end else begin
                    cyc_b_n = 1'b0;
                    case (state)
                        S_FETCH: begin
                            case (SEQTYPE)
                                2'b01:   state_n = S_IND;
                                2'b11:   state_n = S_AUTO1;
                                default: begin
                                    state_n = S_EXEC;
                                    phase_n = PW'(1);
                                end
                            endcase
                        end
                        S_AUTO1: state_n = S_AUTO2;
                        S_AUTO2: state_n = S_IND;
                        default: begin
                            state_n = S_EXEC;
                            phase_n = PW'(1);
                        end
                    endcase
                end
            end
        endcase
        // HALT is only honoured at an instruction boundary
        if (inst_end) begin
            phase_n = '0;
            state_n = (HALT | single) ? S_IDLE : S_FETCH;
        end
    end

    always_comb begin
        ckFetch  = (state == S_FETCH);
        ckAuto1  = (state == S_AUTO1);
        ckAuto2  = (state == S_AUTO2);
        ckInd    = (state == S_IND);
        stbFetch = ckFetch & cyc_b;
        stbAuto1 = ckAuto1 & cyc_b;
        stbAuto2 = ckAuto2 & cyc_b;
        stbInd   = ckInd & cyc_b;
        ck       = '0;
        stb      = '0;
        for (int i = 0; i < NPHASES; i++) begin
            ck[i]  = (state == S_EXEC) && (phase == PW'(i + 1));
            stb[i] = ck[i] & cyc_b;
        end
        running  = (state != S_IDLE);
    end

endmodule

// File: tb/tb_major_state_sequencer.sv
// Bench for major_state_sequencer: queue-based model of the major-state schedule, per-cycle compare,
// directed scenarios with literal timing expectations, then randomized control inputs.
module tb_major_state_sequencer;

    localparam int N = 6;
    localparam int W = 8 + 2 * N + 2;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic         RUN = 1'b0;
    logic         HALT = 1'b0;
    logic         DONE = 1'b0;
    logic [1:0]   SEQTYPE = 2'b00;
`ifdef SEQ_SINGLE_STEP_EN
    logic         STEP = 1'b0;
`endif
    logic         ckFetch, ckAuto1, ckAuto2, ckInd;
    logic         stbFetch, stbAuto1, stbAuto2, stbInd;
    logic [N-1:0] ck, stb;
    logic         running, overrun;
    logic [W-1:0] dut_v;

    major_state_sequencer #(.NPHASES(N), .PW(4)) dut (
`ifdef SEQ_SINGLE_STEP_EN
        .STEP(STEP),
`endif
        .CLK(CLK), .RESET(RESET), .RUN(RUN), .HALT(HALT), .DONE(DONE), .SEQTYPE(SEQTYPE),
        .ckFetch(ckFetch), .ckAuto1(ckAuto1), .ckAuto2(ckAuto2), .ckInd(ckInd),
        .stbFetch(stbFetch), .stbAuto1(stbAuto1), .stbAuto2(stbAuto2), .stbInd(stbInd),
        .ck(ck), .stb(stb), .running(running), .overrun(overrun)
    );

    assign dut_v = {ckFetch, ckAuto1, ckAuto2, ckInd, stbFetch, stbAuto1, stbAuto2, stbInd,
                    ck, stb, running, overrun};

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_fail = 0;
    bit chk_en = 0;
    int cyc = 0;
    int last_f = 0;
    int period = 0;
    int n_fetch = 0;

    // Model: current slot (0 idle, 1 fetch, 2 auto1, 3 auto2, 4 ind, 10+p exec phase p),
    // half (0 = ck only, 1 = ck+stb) and the queue of slots still to come in this instruction.
    int m_cur, m_half;
    int m_q[$];
    bit m_ovr, m_step;
    bit m_r1, m_r2, m_r3, m_s1, m_s2, m_s3;

    int done_k = 0;
    int halt_phase = 0;
    bit rnd = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cur = 0; m_half = 0; m_q.delete(); m_ovr = 0; m_step = 0;
        m_r1 = 0; m_r2 = 0; m_r3 = 0; m_s1 = 0; m_s2 = 0; m_s3 = 0;
    endtask

    task automatic model_step();
        bit start, sstart, fin;
        if (RESET) begin
            model_reset();
            return;
        end
        start = m_r2 & ~m_r3;
        sstart = m_s2 & ~m_s3;
        fin = 0;
        if (m_cur == 0) begin
            if ((start | sstart) && !HALT) begin
                m_cur = 1; m_half = 0; m_ovr = 0; m_step = sstart & ~start;
            end
        end else if (m_half == 0) begin
            m_half = 1;
        end else begin
            m_half = 0;
            if (m_cur == 1) begin
                m_q.delete();
                if (SEQTYPE == 2'b01) m_q = {4};
                else if (SEQTYPE == 2'b11) m_q = {2, 3, 4};
                for (int p = 1; p <= N; p++) m_q.push_back(10 + p);
                m_cur = m_q.pop_front();
            end else if (m_cur > 10 && DONE) begin
                fin = 1;
            end else if (m_q.size() == 0) begin
                fin = 1;
                m_ovr = 1;
            end else begin
                m_cur = m_q.pop_front();
            end
            if (fin) m_cur = (HALT || m_step) ? 0 : 1;
        end
        m_r3 = m_r2; m_r2 = m_r1; m_r1 = RUN;
`ifdef SEQ_SINGLE_STEP_EN
        m_s3 = m_s2; m_s2 = m_s1; m_s1 = STEP;
`endif
    endtask

    function automatic logic [W-1:0] model_vec();
        logic [3:0]   mck;
        logic [N-1:0] eck;
        logic         hb;
        hb  = (m_half == 1);
        mck = {m_cur == 1, m_cur == 2, m_cur == 3, m_cur == 4};
        eck = '0;
        if (m_cur > 10) eck[m_cur - 11] = 1'b1;
        return {mck, mck & {4{hb}}, eck, eck & {N{hb}}, m_cur != 0, m_ovr};
    endfunction

    task automatic drive();
        if (rnd) begin
            if (RESET) RESET = 1'b0;
            else if ($urandom_range(0, 399) == 0) begin
                RESET = 1'b1;
                model_reset();
            end
            if ($urandom_range(0, 19) == 0) RUN = ~RUN;
            if ($urandom_range(0, 39) == 0) HALT = ~HALT;
            SEQTYPE = 2'($urandom_range(0, 3));
            DONE = ($urandom_range(0, 2) == 0);
`ifdef SEQ_SINGLE_STEP_EN
            if ($urandom_range(0, 29) == 0) STEP = ~STEP;
`endif
        end else begin
            DONE = (done_k > 0) && (m_cur == 10 + done_k) && (m_half == 1);
            if (halt_phase > 0 && m_cur == 10 + halt_phase) HALT = 1'b1;
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_step();
        #1;
        drive();
    endtask

    task automatic cycles(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Per-cycle compare and fetch-strobe bookkeeping
    initial begin
        forever begin
            @(negedge CLK);
            cyc++;
            if (chk_en) check("cycle", dut_v, model_vec());
            if (stbFetch) begin
                period = cyc - last_f;
                last_f = cyc;
                n_fetch++;
            end
        end
    end

    initial begin
        int f0;
        int n;
        model_reset();
        cycles(3);
        chk_en = 1;
        check("reset_state", dut_v, 0);
        RESET = 1'b0;
        cycle();

        // RUN rise, plain sequence, DONE in phase 3
        SEQTYPE = 2'b00; done_k = 3; RUN = 1'b1;
        cycles(2);
        check("fetch_not_yet", ckFetch, 0);
        cycle();
        check("fetch_third_edge", ckFetch, 1);
        cycles(20);
        check("len_plain_done3", period, 8);
        check("no_overrun", overrun, 0);

        // Auto-indexed indirect, DONE in phase 1
        SEQTYPE = 2'b11; done_k = 1;
        cycles(25);
        check("len_auto_done1", period, 10);

        // Indirect, DONE in phase 2
        SEQTYPE = 2'b01; done_k = 2;
        cycles(25);
        check("len_ind_done2", period, 8);

        // DONE never asserted
        SEQTYPE = 2'b00; done_k = 0;
        cycles(45);
        check("len_overrun", period, 14);
        check("overrun_set", overrun, 1);

        // HALT raised in phase 2, DONE in phase 4
        done_k = 4; halt_phase = 2;
        n = 0;
        while (running && n < 60) begin
            cycle();
            n++;
        end
        check("halt_reached", running, 0);
        check("overrun_sticky", overrun, 1);
        halt_phase = 0;
        f0 = n_fetch;
        cycles(20);
        check("no_restart_run_high", n_fetch - f0, 0);

        // New RUN edge after halt restarts and clears overrun
        HALT = 1'b0; RUN = 1'b0;
        cycles(4);
        RUN = 1'b1;
        cycles(5);
        check("restart_running", running, 1);
        check("overrun_cleared", overrun, 0);

        // Asynchronous reset inside EXEC(3)
        done_k = 0;
        n = 0;
        while (!ck[2] && n < 100) begin
            cycle();
            n++;
        end
        check("reach_exec3", ck[2], 1);
        RESET = 1'b1;
        model_reset();
        #1;
        check("async_reset_outputs", dut_v, 0);
        cycles(2);
        RESET = 1'b0; RUN = 1'b0;
        cycles(6);
        check("idle_after_reset", dut_v, 0);

`ifdef SEQ_SINGLE_STEP_EN
        done_k = 2;
        for (int s = 0; s < 2; s++) begin
            f0 = n_fetch;
            STEP = 1'b1;
            cycles(4);
            STEP = 1'b0;
            cycles(30);
            check("step_one_fetch", n_fetch - f0, 1);
            check("step_back_idle", running, 0);
        end
`endif

        rnd = 1;
        cycles(3000);
        rnd = 0;
        RESET = 1'b0;
        cycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
